// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round controller.
package aes_pkg;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  // Round counter must represent 0..nr inclusive.
  function automatic int unsigned round_width(input int unsigned nr);
    return $clog2(nr + 1);
  endfunction

  localparam int unsigned ROUND_W_128 = round_width(NR_128);
  localparam int unsigned ROUND_W_MAX = round_width(NR_256);

  typedef enum logic [2:0] {
    IDLE,
    ARK0,
    SB,
    SR,
    MC,
    ARK,
    FINISH,
    ERR
  } aes_state_e;

  typedef struct packed {
    logic sb;
    logic sr;
    logic mc;
    logic ark;
  } stage_ena_t;

endpackage

// File: rtl/aes_stage_timer.sv
// Per-stage wait counter: flags when a stage may accept done and when it has run out of time.
module aes_stage_timer #(
  parameter int unsigned STAGE_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic armed,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(STAGE_TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at the limit; the controller always leaves the stage by then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign armed  = (cnt_q != '0);
  assign expire = (cnt_q == CNT_W'(STAGE_TIMEOUT - 1));

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES encryption datapath:
// ARK0, then (SB, SR, MC, ARK) per round with MC skipped in the last round.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR            = NR_128,
  parameter int unsigned ROUND_W       = ROUND_W_128,
  parameter int unsigned STAGE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sb_done,
  input  logic               sr_done,
  input  logic               mc_done,
  input  logic               ark_done,
  output logic               sb_ena,
  output logic               sr_ena,
  output logic               mc_ena,
  output logic               ark_ena,
  output logic [ROUND_W-1:0] round,
  output logic               load_sel,
  output logic               busy,
  output logic               done,
  output logic               err
);

  aes_state_e         state_q, state_d;
  stage_ena_t         ena_q, ena_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               load_sel_q, load_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               in_stage, stage_done, accept;
  logic               timer_clr, armed, expire;

  assign in_stage  = state_q inside {ARK0, SB, SR, MC, ARK};
  assign timer_clr = (state_d != state_q);

  aes_stage_timer #(
    .STAGE_TIMEOUT(STAGE_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clr),
    .enable(in_stage),
    .armed (armed),
    .expire(expire)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    load_sel_d = load_sel_q;
    stage_done = 1'b0;
    accept     = 1'b0;

    case (state_q)
      ARK0, ARK: stage_done = ark_done;
      SB:        stage_done = sb_done;
      SR:        stage_done = sr_done;
      MC:        stage_done = mc_done;
      default:   stage_done = 1'b0;
    endcase
    // The first cycle of a stage may still see the previous stage's done.
    accept = stage_done && armed;

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d    = ARK0;
          round_d    = '0;
          load_sel_d = 1'b1;
        end
      end
      ARK0: begin
        if (accept) begin
          state_d    = SB;
          round_d    = ROUND_W'(1);
          load_sel_d = 1'b0;
        end
      end
      SB: if (accept) state_d = SR;
      SR: if (accept) state_d = (round_q < ROUND_W'(NR)) ? MC : ARK;
      MC: if (accept) state_d = ARK;
      ARK: begin
        if (accept) begin
          if (round_q == ROUND_W'(NR)) begin
            state_d = FINISH;
          end else begin
            state_d = SB;
            round_d = round_q + ROUND_W'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (in_stage && expire && !accept) begin
      state_d    = ERR;
      load_sel_d = 1'b0;
    end

    ena_d.sb  = (state_d == SB);
    ena_d.sr  = (state_d == SR);
    ena_d.mc  = (state_d == MC);
    ena_d.ark = (state_d == ARK0) || (state_d == ARK);
    busy_d    = state_d inside {ARK0, SB, SR, MC, ARK};
    done_d    = (state_d == FINISH);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ena_q      <= '0;
      round_q    <= '0;
      load_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ena_q      <= ena_d;
      round_q    <= round_d;
      load_sel_q <= load_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sb_ena   = ena_q.sb;
  assign sr_ena   = ena_q.sr;
  assign mc_ena   = ena_q.mc;
  assign ark_ena  = ena_q.ark;
  assign round    = round_q;
  assign load_sel = load_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencer for the iterative AES-128 encryption datapath. It drives the level-held `ena` / `done` handshake of the round sub-blocks: subbytes, shiftrows, mixcolumns and addroundkey.
- Order: initial AddRoundKey, then NR rounds; the final round skips MixColumns.
- Exposes the current round number for key-schedule selection and a state-register input select.
- Has a start/busy/done interface to the top level and a per-stage watchdog.

Parameters:
- NR, 10, number of AES rounds (10/12/14 for 128/192/256-bit keys).
- ROUND_W, 4, width of the round counter; must hold NR.
- STAGE_TIMEOUT, 16, maximum cycles spent in one stage waiting for its done before raising err. Must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one encryption; sampled only in IDLE or ERR.
- sb_done  in  1  subbytes stage done.
- sr_done  in  1  shiftrows stage done.
- mc_done  in  1  mixcolumns stage done.
- ark_done  in  1  addroundkey stage done.
- sb_ena  out  1  subbytes enable, level-held.
- sr_ena  out  1  shiftrows enable.
- mc_ena  out  1  mixcolumns enable.
- ark_ena  out  1  addroundkey enable.
- round  out  ROUND_W  current round, 0..NR; selects the round key.
- load_sel  out  1  1 = state register loads plaintext, 0 = loopback from the datapath.
- busy  out  1  high from the cycle after start is accepted until FINISH.
- done  out  1  single-cycle pulse when the ciphertext is valid.
- err  out  1  sticky stage-timeout flag.

Behaviour:
Reset (rst = 0, asynchronous):
- FSM goes to IDLE.
- All enables, busy, done and err are 0; round = 0; load_sel = 0.

FSM states and transitions:
- IDLE: on start → ARK0, with round = 0 and load_sel = 1.
- ARK0: on accepted ark_done → SB, with round = 1 and load_sel = 0.
- SB: on sb_done → SR.
- SR: on sr_done → MC if round < NR, else → ARK.
- MC: on mc_done → ARK.
- ARK: on ark_done, if round = NR → FINISH; else round+1 and → SB.
- FINISH: done = 1 and busy = 0 for one cycle, then → IDLE. round holds NR until the next start.
- ERR: all enables 0, busy = 0, err = 1. On start → ARK0 and err clears.

Outputs and handshake:
- All outputs are registered. The stage enable is 1 for every cycle the FSM is in that stage's state, and 0 otherwise.
- At most one enable is high in any cycle.
- Done acceptance: a stage's done counts only in the second or later cycle of that state (wait counter ≥ 1). This masks the stale done a sub-block holds for one cycle after its ena falls.
- Done inputs for stages other than the current one are ignored.

Watchdog:
- A wait counter clears on every state entry and increments each cycle.
- If the counter = STAGE_TIMEOUT−1 and no accepted done is present → ERR on the next edge.

Latency:
- With 1-cycle sub-blocks, each stage takes exactly 2 cycles.
- For NR = 10: start sampled in cycle 0, ARK0 in cycles 1–2, SB of round 1 starts in cycle 3, done pulses in cycle 81.

Boundary cases:
- start while busy or in FINISH: ignored.
- start held high continuously: a new encryption begins the cycle after FINISH returns the FSM to IDLE.
- Done arriving in the same cycle the counter hits STAGE_TIMEOUT−1: done wins and there is no error.
- Reset mid-operation: immediate return to reset values; no done pulse.

Decomposition:
- aes_pkg holds:
  - the FSM state typedef: IDLE, ARK0, SB, SR, MC, ARK, FINISH, ERR;
  - constants NR_128 = 10, NR_192 = 12, NR_256 = 14;
  - the ROUND_W derivation.
- One sub-module, aes_stage_timer:
  - inputs: clear, enable;
  - parameter: STAGE_TIMEOUT;
  - outputs: armed (count ≥ 1) and expire (count = STAGE_TIMEOUT−1).

Test Plan:
- Nominal run: reset; NR = 10 with 1-cycle responder models; start pulse in cycle 0.
  - Expected enable order: ark, then (sb, sr, mc, ark) ×9, then sb, sr, ark.
  - mc_ena is never high when round = 10; done pulses only in cycle 81; round = 10 at done.
- Stale done: responder keeps done high one cycle after ena falls.
  - No stage is skipped; each stage lasts exactly 2 cycles; total latency unchanged.
- Timeout: hold mc_done = 0 in round 3 with STAGE_TIMEOUT = 16.
  - mc_ena stays high 16 cycles, then ERR: err = 1, all enables 0, busy = 0.
  - A later start clears err and completes normally.
- Done at the limit: mc_done first asserted in the 16th MC cycle → no err; → ARK.
- Start while busy: extra start pulses at cycles 10 and 81 are ignored; only one done pulse.
  - A start at cycle 82 begins a second run, with ark_ena high in cycle 83.
- Reset mid-operation: rst low at cycle 40 → all outputs at reset values within the same cycle (asynchronous).
  - After release, the FSM stays idle until the next start.
